inv_subbytes_seq: RTL and testbench

//  Iterative AES InvSubBytes stage for the decryption datapath. Consumes the
//  128-bit state produced by inv_shiftrows and substitutes every byte through
//  the inverse S-box, BYTES_PER_CYCLE bytes per clock. This trades latency for
//  S-box area. A start/done handshake lets the round controller sequence it

---
 rtl/inv_subbytes_seq.sv | 126 ++++++++++++
 tb/tb_inv_subbytes_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes: substitutes the 128-bit state through the
// inverse S-box BYTES_PER_CYCLE bytes per clock, with a start/done handshake.
module inv_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done_sb
);

    localparam int N  = BYTES_PER_CYCLE;
    localparam int G  = 16 / N;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] LAST = CW'(G - 1);

    // Refuse to elaborate with a group size that does not tile 16 bytes.
    generate
        if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_param
            $error("inv_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 inverse S-box, entry 0 first.
    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [8*N-1:0]  work [2**CW];   // working state, one entry per group
    logic [8*N-1:0]  cur_grp;
    logic [8*N-1:0]  sub_grp;
    logic            load;
    logic            last;

    assign load    = start && (state != RUN);
    assign last    = (state == RUN) && (cnt == LAST);
    assign busy    = (state == RUN);
    assign done_sb = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: IDLE/DONE accept start, RUN exits after the last group.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // N parallel inverse S-box lookups on the group selected by the counter.
    always_comb begin
        cur_grp = work[cnt];
        sub_grp = '0;
        for (int j = 0; j < N; j++) begin
            sub_grp[8*N-1-8*j -: 8] = INV_SBOX[cur_grp[8*N-1-8*j -: 8]];
        end
    end

    // Group counter: cleared on capture, stepped once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst)                 cnt <= '0;
        else if (load)           cnt <= '0;
        else if (state == RUN)   cnt <= cnt + CW'(1);
    end

    // Working register: captures state_in, then rewrites one group per cycle.
    always_ff @(posedge clk) begin
        // NOTE: the working array is deliberately not reset; it is always
        // fully overwritten on capture before any of it is observed.
        if (load) begin
            for (int g = 0; g < G; g++) begin
                work[g] <= state_in[127-8*N*g -: 8*N];
            end
        end else if (state == RUN) begin
            work[cnt] <= sub_grp;
        end
    end

    // Result register: updated only on the edge that finishes the last group.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_out <= '0;
        end else if (last) begin
            for (int g = 0; g < G; g++) begin
                state_out[127-8*N*g -: 8*N] <= (g == G - 1) ? sub_grp : work[g];
            end
        end
    end

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed bench for inv_subbytes_seq: main instance at 4 bytes/cycle plus
// one instance per legal width for the latency/result sweep.
module tb_inv_subbytes_seq;

    localparam logic [127:0] FIPS_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         busy;
    logic         done_sb;

    // Sweep instances: index 0..4 -> 1,2,4,8,16 bytes per cycle.
    logic [127:0] sw_out  [5];
    logic         sw_busy [5];
    logic         sw_done [5];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inv_subbytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .state_out(state_out), .busy(busy), .done_sb(done_sb)
    );
    inv_subbytes_seq #(.BYTES_PER_CYCLE(1)) u_n1 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .state_out(sw_out[0]), .busy(sw_busy[0]), .done_sb(sw_done[0])
    );
    inv_subbytes_seq #(.BYTES_PER_CYCLE(2)) u_n2 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .state_out(sw_out[1]), .busy(sw_busy[1]), .done_sb(sw_done[1])
    );
    inv_subbytes_seq #(.BYTES_PER_CYCLE(4)) u_n4 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .state_out(sw_out[2]), .busy(sw_busy[2]), .done_sb(sw_done[2])
    );
    inv_subbytes_seq #(.BYTES_PER_CYCLE(8)) u_n8 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .state_out(sw_out[3]), .busy(sw_busy[3]), .done_sb(sw_done[3])
    );
    inv_subbytes_seq #(.BYTES_PER_CYCLE(16)) u_n16 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .state_out(sw_out[4]), .busy(sw_busy[4]), .done_sb(sw_done[4])
    );

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single capture + wait for done; checks latency and result.
    task automatic run_vector(input logic [127:0] din, input logic [127:0] dexp, input string name);
        int lat;
        state_in = din;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        else n_pass++;
        lat = 0;
        while (done_sb !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 4) $display("FAIL %s latency: got %0d want 4", name, lat);
        else n_pass++;
        n_checks++;
        if (state_out !== dexp) $display("FAIL %s state_out: got %h want %h", name, state_out, dexp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; state_in = '0;
        tick(); tick();
        n_checks++;
        if (state_out !== 128'h0) $display("FAIL reset state_out: got %h want 0", state_out);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (done_sb !== 1'b0) $display("FAIL reset done_sb: got %b want 0", done_sb);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips();
        run_vector(FIPS_IN, FIPS_OUT, "fips_c1");
        tick();
        n_checks++;
        if (done_sb !== 1'b0 || busy !== 1'b0)
            $display("FAIL fips_after_done: got done=%b busy=%b want 0/0", done_sb, busy);
        else n_pass++;
        n_checks++;
        if (state_out !== FIPS_OUT) $display("FAIL fips_hold: got %h want %h", state_out, FIPS_OUT);
        else n_pass++;
    endtask

    task automatic test_corners();
        run_vector({16{8'h00}}, {16{8'h52}}, "corner_00");
        tick();
        run_vector({16{8'h63}}, {16{8'h00}}, "corner_63");
        tick();
        run_vector({16{8'hff}}, {16{8'h7d}}, "corner_ff");
        tick();
        run_vector({16{8'h7c}}, {16{8'h01}}, "corner_7c");
        tick();
    endtask

    task automatic test_start_during_run();
        int dones;
        state_in = FIPS_IN;
        start    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            state_in = {16{8'h11 * (i + 1)}};
            start    = 1'b1;
            tick();
        end
        start    = 1'b0;
        state_in = {16{8'hff}};
        tick();
        n_checks++;
        if (done_sb !== 1'b1) $display("FAIL busy_start done_timing: got %b want 1", done_sb);
        else n_pass++;
        n_checks++;
        if (state_out !== FIPS_OUT) $display("FAIL busy_start state_out: got %h want %h", state_out, FIPS_OUT);
        else n_pass++;
        dones = (done_sb === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_sb === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 1) $display("FAIL busy_start done_count: got %0d want 1", dones);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        state_in = FIPS_IN;
        start    = 1'b1;
        tick();
        lat = 0;
        while (done_sb !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (state_out !== FIPS_OUT) $display("FAIL b2b first state_out: got %h want %h", state_out, FIPS_OUT);
        else n_pass++;
        state_in = {16{8'h00}};
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b no_gap busy: got %b want 1", busy);
        else n_pass++;
        lat = 1;
        while (done_sb !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 5) $display("FAIL b2b done_spacing: got %0d want 5", lat);
        else n_pass++;
        n_checks++;
        if (state_out !== {16{8'h52}}) $display("FAIL b2b second state_out: got %h want %h", state_out, {16{8'h52}});
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int dones;
        state_in = {16{8'hff}};
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done_sb !== 1'b0)
            $display("FAIL midrst flags: got busy=%b done=%b want 0/0", busy, done_sb);
        else n_pass++;
        n_checks++;
        if (state_out !== 128'h0) $display("FAIL midrst state_out: got %h want 0", state_out);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_sb === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) $display("FAIL midrst spurious_done: got %0d want 0", dones);
        else n_pass++;
        run_vector(FIPS_IN, FIPS_OUT, "after_midrst");
        tick();
    endtask

    task automatic test_sweep();
        int exp_lat [5] = '{16, 8, 4, 2, 1};
        int seen    [5];
        logic [127:0] got [5];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen[i] = 0;
            got[i]  = '0;
        end
        state_in = FIPS_IN;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int i = 0; i < 5; i++) begin
                if (sw_done[i] === 1'b1 && seen[i] == 0) begin
                    seen[i] = c;
                    got[i]  = sw_out[i];
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (seen[i] !== exp_lat[i]) $display("FAIL sweep[%0d] latency: got %0d want %0d", i, seen[i], exp_lat[i]);
            else n_pass++;
            n_checks++;
            if (got[i] !== FIPS_OUT) $display("FAIL sweep[%0d] state_out: got %h want %h", i, got[i], FIPS_OUT);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; state_in = '0;
        test_reset();
        test_fips();
        test_corners();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
